// File: rtl/pattern_generator.sv
// Serial pattern generator: accepts a parallel word over valid/ready and
// shifts it out one bit per clock, optionally repeating it back-to-back,
// then idles the line for a fixed gap before accepting the next word.
module pattern_generator #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 2,
  parameter int RPT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [RPT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             serial_pattern,
  output logic             enable,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] LAST  = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GLOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BW-1:0]    bit_q, bit_d, bit_inc;
  logic [RPT_W-1:0] pass_q, pass_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             serial_d, enable_d, busy_d, done_d, ready_d;
  logic [WIDTH-1:0] order;
  logic             first_bit;

  // Captured word rearranged into transmit order so the bit index maps directly.
  for (genvar k = 0; k < WIDTH; k++) begin : g_order
    if (MSB_FIRST != 0) begin : g_msb
      assign order[k] = word_q[WIDTH-1-k];
    end else begin : g_lsb
      assign order[k] = word_q[k];
    end
  end

  assign first_bit = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
  assign bit_inc   = bit_q + 1'b1;

  // State and registered outputs; every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      word_q         <= '0;
      bit_q          <= '0;
      pass_q         <= '0;
      gap_q          <= '0;
      serial_pattern <= 1'b0;
      enable         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      din_ready      <= 1'b1;
    end else begin
      state_q        <= state_d;
      word_q         <= word_d;
      bit_q          <= bit_d;
      pass_q         <= pass_d;
      gap_q          <= gap_d;
      serial_pattern <= serial_d;
      enable         <= enable_d;
      busy           <= busy_d;
      done           <= done_d;
      din_ready      <= ready_d;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so they register
  // in step with the state they belong to.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    bit_d    = bit_q;
    pass_d   = pass_q;
    gap_d    = gap_q;
    serial_d = 1'b0;
    enable_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ready_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (din_valid && din_ready && !abort) begin
          word_d   = din;
          pass_d   = repeat_cnt;
          bit_d    = '0;
          serial_d = first_bit;
          enable_d = 1'b1;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_q == LAST) begin
          if (pass_q == '0) begin
            done_d = 1'b1;
            if (GAP_CYCLES > 0) begin
              gap_d   = GLOAD;
              busy_d  = 1'b1;
              ready_d = 1'b0;
              state_d = GAP;
            end else begin
              state_d = IDLE;
            end
          end else begin
            pass_d   = pass_q - 1'b1;
            bit_d    = '0;
            serial_d = order[0];
            enable_d = 1'b1;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
          end
        end else begin
          bit_d    = bit_inc;
          serial_d = order[bit_inc];
          enable_d = 1'b1;
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end
      GAP: begin
        if (abort || gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d   = gap_q - 1'b1;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: instance a is MSB-first with a
// 2-cycle gap, instance b is LSB-first with no gap.
module tb_pattern_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [3:0] rpt;
  logic       abort;
  logic       va, vb;
  logic       ra, sa, ea, ba, da;
  logic       rb, sb, eb, bb, db;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_generator #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(2), .RPT_W(4)) u_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(va), .din_ready(ra),
    .repeat_cnt(rpt), .abort(abort), .serial_pattern(sa), .enable(ea),
    .busy(ba), .done(da)
  );

  pattern_generator #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0), .RPT_W(4)) u_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(vb), .din_ready(rb),
    .repeat_cnt(rpt), .abort(abort), .serial_pattern(sb), .enable(eb),
    .busy(bb), .done(db)
  );

  typedef struct {
    bit         sel;     // 0: instance a, 1: instance b
    logic [7:0] din;
    logic [3:0] rpt;
    logic [7:0] seq;     // expected bits in transmit order, leftmost first
    int         passes;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic obs(input bit sel, output logic en, output logic ser,
                     output logic bsy, output logic dn, output logic rdy);
    en  = sel ? eb : ea;
    ser = sel ? sb : sa;
    bsy = sel ? bb : ba;
    dn  = sel ? db : da;
    rdy = sel ? rb : ra;
  endtask

  // Called at a negedge in IDLE; returns at the negedge showing the first bit.
  task automatic start(input bit sel, input logic [7:0] d, input logic [3:0] r);
    logic en, ser, bsy, dn, rdy;
    obs(sel, en, ser, bsy, dn, rdy);
    chk("ready_before_start", rdy, 1'b1);
    din = d;
    rpt = r;
    if (sel) vb = 1'b1; else va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
  endtask

  // Checks all passes, the done pulse and the gap; returns at an IDLE negedge.
  task automatic check_stream(input bit sel, input logic [7:0] seq, input int passes);
    logic en, ser, bsy, dn, rdy;
    logic [7:0] s;
    for (int p = 0; p < passes; p++) begin
      s = seq;
      for (int k = 0; k < 8; k++) begin
        obs(sel, en, ser, bsy, dn, rdy);
        chk("enable_shift", en, 1'b1);
        chk("serial_bit", ser, s[7]);
        chk("done_early", dn, 1'b0);
        chk("busy_shift", bsy, 1'b1);
        chk("ready_shift", rdy, 1'b0);
        s = s << 1;
        @(negedge clk);
      end
    end
    obs(sel, en, ser, bsy, dn, rdy);
    chk("done_pulse", dn, 1'b1);
    chk("enable_after", en, 1'b0);
    chk("serial_after", ser, 1'b0);
    if (!sel) begin
      chk("busy_gap1", bsy, 1'b1);
      chk("ready_gap1", rdy, 1'b0);
      @(negedge clk);
      obs(sel, en, ser, bsy, dn, rdy);
      chk("enable_gap2", en, 1'b0);
      chk("done_gap2", dn, 1'b0);
      chk("busy_gap2", bsy, 1'b1);
      chk("ready_gap2", rdy, 1'b0);
      @(negedge clk);
      obs(sel, en, ser, bsy, dn, rdy);
      chk("ready_idle", rdy, 1'b1);
      chk("busy_idle", bsy, 1'b0);
      chk("enable_idle", en, 1'b0);
      chk("done_idle", dn, 1'b0);
    end else begin
      chk("busy_nogap", bsy, 1'b0);
      chk("ready_nogap", rdy, 1'b1);
    end
  endtask

  initial begin
    logic en, ser, bsy, dn, rdy;

    vecs[0] = '{sel: 1'b0, din: 8'hA5, rpt: 4'd0,  seq: 8'b1010_0101, passes: 1};
    vecs[1] = '{sel: 1'b1, din: 8'h0F, rpt: 4'd2,  seq: 8'b1111_0000, passes: 3};
    vecs[2] = '{sel: 1'b0, din: 8'h3C, rpt: 4'd1,  seq: 8'b0011_1100, passes: 2};
    vecs[3] = '{sel: 1'b1, din: 8'h01, rpt: 4'd0,  seq: 8'b1000_0000, passes: 1};
    vecs[4] = '{sel: 1'b0, din: 8'h80, rpt: 4'd15, seq: 8'b1000_0000, passes: 16};
    vecs[5] = '{sel: 1'b1, din: 8'hC8, rpt: 4'd0,  seq: 8'b0001_0011, passes: 1};

    rst = 1'b1; va = 1'b0; vb = 1'b0; din = '0; rpt = '0; abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      obs(s[0], en, ser, bsy, dn, rdy);
      chk("reset_enable", en, 1'b0);
      chk("reset_serial", ser, 1'b0);
      chk("reset_busy", bsy, 1'b0);
      chk("reset_done", dn, 1'b0);
      chk("reset_ready", rdy, 1'b1);
    end
    rst = 1'b0;
    @(negedge clk);

    // Table-driven transfers on both instances.
    for (int i = 0; i < 6; i++) begin
      start(vecs[i].sel, vecs[i].din, vecs[i].rpt);
      check_stream(vecs[i].sel, vecs[i].seq, vecs[i].passes);
    end
    @(negedge clk);

    // din_valid held high: one capture per IDLE visit, busy-time word dropped.
    din = 8'hA5; va = 1'b1;
    @(negedge clk);
    din = 8'h00;
    check_stream(1'b0, 8'b1010_0101, 1);
    din = 8'hFF;
    @(negedge clk);
    va = 1'b0;
    check_stream(1'b0, 8'b1111_1111, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("held_valid_no_extra", ea, 1'b0);
      chk("held_valid_ready", ra, 1'b1);
    end

    // Abort while bit 3 is on the line.
    start(1'b0, 8'hA5, 4'd0);
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("abort_bit3_value", sa, 1'b0);
    chk("abort_bit3_enable", ea, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_enable", ea, 1'b0);
    chk("abort_serial", sa, 1'b0);
    chk("abort_ready", ra, 1'b1);
    chk("abort_busy", ba, 1'b0);
    chk("abort_done", da, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", da, 1'b0);
      chk("abort_no_gap", ba, 1'b0);
    end

    // abort and din_valid together in IDLE: abort wins, then a clean start.
    din = 8'h33; rpt = 4'd0; va = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort_idle_enable", ea, 1'b0);
    chk("abort_idle_ready", ra, 1'b1);
    chk("abort_idle_busy", ba, 1'b0);
    abort = 1'b0;
    @(negedge clk);
    va = 1'b0;
    check_stream(1'b0, 8'b0011_0011, 1);

    // Asynchronous reset between edges in the middle of a word.
    start(1'b0, 8'hFF, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_enable", ea, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_enable", ea, 1'b0);
    chk("async_rst_serial", sa, 1'b0);
    chk("async_rst_busy", ba, 1'b0);
    chk("async_rst_ready", ra, 1'b1);
    chk("async_rst_done", da, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", da, 1'b0);
    start(1'b0, 8'h96, 4'd0);
    check_stream(1'b0, 8'b1001_0110, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
